// File: rtl/mem_loader_ctrl_pkg.sv
// ============================================================================
//  Module   : mem_loader_ctrl_pkg
//  Brief    : Shared states, status flags and sizes for the memory loader.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package mem_loader_ctrl_pkg;

  localparam int COUNT_BYTES = 2;
  localparam int WORD_BYTES  = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    RUN   = 3'd4,
    ERR   = 3'd5
  } ldrState_t;

  typedef struct packed {
    logic cpuReset;
    logic rxReady;
    logic busy;
    logic done;
    logic error;
  } ldrFlags_t;

  // Status outputs are a pure function of the state being entered.
  function automatic ldrFlags_t stateFlags(input ldrState_t s);
    ldrFlags_t f;
    f.cpuReset = (s != RUN);
    f.rxReady  = (s == COUNT) || (s == DATA);
    f.busy     = (s == COUNT) || (s == DATA) || (s == WRITE);
    f.done     = (s == RUN);
    f.error    = (s == ERR);
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_loader_ctrl_word_pack.sv
// ============================================================================
//  Module   : ldr_word_pack
//  Brief    : Packs little-endian bytes into a word and flags the last byte.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ldr_word_pack
  import mem_loader_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byteEn,
  input  logic [7:0]  byteIn,
  output logic [31:0] word,
  output logic        wordDone
);

  localparam int IW = $clog2(WORD_BYTES);
  localparam logic [IW-1:0] c_lastIdx = IW'(WORD_BYTES - 1);

  logic [IW-1:0] r_idx;
  logic [31:0]   r_word;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (byteEn) begin
      r_word[8*r_idx +: 8] <= byteIn;
      r_idx                <= (r_idx == c_lastIdx) ? '0 : r_idx + 1'b1;
    end
  end

  // Word including the byte being accepted this cycle, so the top can latch it
  // on the same edge that completes the word.
  always_comb begin
    word                = r_word;
    word[8*r_idx +: 8]  = byteIn;
  end

  assign wordDone = byteEn && (r_idx == c_lastIdx);

endmodule

`default_nettype wire

// File: rtl/mem_loader_ctrl.sv
// ============================================================================
//  Module   : mem_loader_ctrl
//  Brief    : Byte-stream program loader: holds the CPU in reset and writes words.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mem_loader_ctrl
  import mem_loader_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADR  = 32'h0000_0000,
  parameter int          MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_req,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        cpu_reset,
  output logic        Ext_MemWrite,
  output logic [31:0] Ext_WriteData,
  output logic [31:0] Ext_DataAdr,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [16:0] c_maxWords = 17'(MAX_WORDS);

  ldrState_t   r_state;
  ldrFlags_t   r_flags;
  logic        r_memWrite;
  logic [31:0] r_writeData;
  logic [31:0] r_dataAdr;
  logic [15:0] r_count;
  logic [15:0] r_index;
  logic        r_cntByte;

  logic        w_accept;
  logic        w_cntIsLast;
  logic [15:0] w_fullCount;
  logic [31:0] w_word;
  logic        w_wordDone;

  assign w_accept    = rx_valid && r_flags.rxReady;
  assign w_cntIsLast = (r_cntByte == 1'(COUNT_BYTES - 1));
  assign w_fullCount = {rx_data, r_count[7:0]};

  ldr_word_pack u_pack (
    .clk      (clk),
    .reset    (reset),
    .clear    (r_state == COUNT),
    .byteEn   ((r_state == DATA) && w_accept),
    .byteIn   (rx_data),
    .word     (w_word),
    .wordDone (w_wordDone)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_flags     <= stateFlags(IDLE);
      r_memWrite  <= 1'b0;
      r_writeData <= '0;
      r_dataAdr   <= BASE_ADR;
      r_count     <= '0;
      r_index     <= '0;
      r_cntByte   <= 1'b0;
    end else begin
      r_memWrite <= 1'b0;
      case (r_state)
        IDLE, RUN, ERR: begin
          if (load_req) begin
            r_state   <= COUNT;
            r_flags   <= stateFlags(COUNT);
            r_count   <= '0;
            r_index   <= '0;
            r_cntByte <= 1'b0;
          end
        end
        COUNT: begin
          if (w_accept) begin
            if (!w_cntIsLast) begin
              r_count[7:0] <= rx_data;
              r_cntByte    <= r_cntByte + 1'b1;
            end else begin
              r_count   <= w_fullCount;
              r_cntByte <= 1'b0;
              r_index   <= '0;
              if (w_fullCount == 16'd0) begin
                r_state <= RUN;
                r_flags <= stateFlags(RUN);
              end else if ({1'b0, w_fullCount} > c_maxWords) begin
                r_state <= ERR;
                r_flags <= stateFlags(ERR);
              end else begin
                r_state <= DATA;
                r_flags <= stateFlags(DATA);
              end
            end
          end
        end
        DATA: begin
          if (w_wordDone) begin
            r_writeData <= w_word;
            r_dataAdr   <= BASE_ADR + {14'd0, r_index, 2'b00};
            r_memWrite  <= 1'b1;
            r_state     <= WRITE;
            r_flags     <= stateFlags(WRITE);
          end
        end
        WRITE: begin
          if (r_index + 16'd1 == r_count) begin
            r_state <= RUN;
            r_flags <= stateFlags(RUN);
          end else begin
            r_index <= r_index + 16'd1;
            r_state <= DATA;
            r_flags <= stateFlags(DATA);
          end
        end
        default: begin
          r_state <= IDLE;
          r_flags <= stateFlags(IDLE);
        end
      endcase
    end
  end

  assign rx_ready      = r_flags.rxReady;
  assign cpu_reset     = r_flags.cpuReset;
  assign busy          = r_flags.busy;
  assign done          = r_flags.done;
  assign error         = r_flags.error;
  assign Ext_MemWrite  = r_memWrite;
  assign Ext_WriteData = r_writeData;
  assign Ext_DataAdr   = r_dataAdr;

endmodule

`default_nettype wire

// File: tb/tb_mem_loader_ctrl.sv
// ============================================================================
//  Module   : tb_mem_loader_ctrl
//  Brief    : Scoreboard bench for mem_loader_ctrl with directed byte streams.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_loader_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_req = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready, cpu_reset, Ext_MemWrite, busy, done, error;
  logic [31:0] Ext_WriteData, Ext_DataAdr;

  int nTests = 0;
  int nFails = 0;
  logic [63:0] expQ[$];
  logic prevMw = 1'b0;

  mem_loader_ctrl #(.BASE_ADR(32'h0000_0000), .MAX_WORDS(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_req     (load_req),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .cpu_reset    (cpu_reset),
    .Ext_MemWrite (Ext_MemWrite),
    .Ext_WriteData(Ext_WriteData),
    .Ext_DataAdr  (Ext_DataAdr),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Write monitor: pops the scoreboard on every strobe.
  always @(negedge clk) begin
    if (Ext_MemWrite) begin
      check("strobe_one_cycle", {31'd0, prevMw}, 32'd0);
      check("write_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      if (expQ.size() == 0) begin
        nTests++;
        nFails++;
        $display("FAIL unexpected_write: got data 0x%08h adr 0x%08h, required no write",
                 Ext_WriteData, Ext_DataAdr);
      end else begin
        check("write_data", Ext_WriteData, expQ[0][63:32]);
        check("write_adr", Ext_DataAdr, expQ[0][31:0]);
        void'(expQ.pop_front());
      end
    end
    prevMw <= Ext_MemWrite;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gap < 0 selects a random 0..5 cycle stall before the byte.
  task automatic sendByte(input logic [7:0] b, input int gap);
    int g;
    bit ok;
    g = (gap < 0) ? int'($urandom_range(0, 5)) : gap;
    repeat (g) tick();
    rx_valid = 1'b1;
    rx_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      nTests++;
      nFails++;
      $display("FAIL rx_ready_timeout: got rx_ready=0 for 50 cycles, required 1");
    end
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic sendWord(input logic [31:0] w, input logic [31:0] adr, input int gap);
    expQ.push_back({w, adr});
    for (int k = 0; k < 4; k++) sendByte(w[8*k +: 8], gap);
  endtask

  task automatic sendCount(input logic [15:0] n);
    sendByte(n[7:0], 0);
    sendByte(n[15:8], 0);
  endtask

  task automatic startLoad();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic waitDone(input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check(name, {31'd0, done}, 32'd1);
    #1;
  endtask

  task automatic waitError(input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (error) break;
    end
    check(name, {31'd0, error}, 32'd1);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) tick();
    check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_memwrite", {31'd0, Ext_MemWrite}, 32'd0);
    check("rst_wdata", Ext_WriteData, 32'h0);
    check("rst_adr", Ext_DataAdr, 32'h0);
    check("rst_status", {29'd0, busy, done, error}, 32'd0);
    reset = 1'b0;
    tick();
    check("idle_cpu_reset", {31'd0, cpu_reset}, 32'd1);

    // Two-word program image.
    startLoad();
    check("count_busy_ready", {30'd0, busy, rx_ready}, 32'd3);
    sendCount(16'd2);
    sendWord(32'h00A00513, 32'h0, 0);
    sendWord(32'h00B00593, 32'h4, 0);
    waitDone("done_2w");
    check("run_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check("run_busy_err", {30'd0, busy, error}, 32'd0);

    // Reload from RUN overwrites from the base address.
    startLoad();
    check("reload_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("reload_done", {31'd0, done}, 32'd0);
    sendCount(16'd1);
    sendWord(32'h11223344, 32'h0, 0);
    waitDone("done_reload");

    // Zero count goes straight to RUN; write data holds its last value.
    startLoad();
    sendCount(16'd0);
    waitDone("done_zero");
    check("zero_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check("hold_wdata", Ext_WriteData, 32'h11223344);

    // Count one above the limit.
    startLoad();
    sendCount(16'h0041);
    waitError("err_over");
    check("err_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("err_done_busy", {30'd0, done, busy}, 32'd0);
    startLoad();
    check("err_cleared", {31'd0, error}, 32'd0);
    check("err_reload_busy", {31'd0, busy}, 32'd1);

    // Three words with random stalls; load_req held high while busy.
    sendCount(16'd3);
    load_req = 1'b1;
    sendWord(32'hCAFEF00D, 32'h0, -1);
    load_req = 1'b0;
    sendWord(32'h01234567, 32'h4, -1);
    sendWord(32'h89ABCDEF, 32'h8, -1);
    waitDone("done_gaps");

    // Reset in the middle of a word, then a clean single-word session.
    startLoad();
    sendCount(16'd1);
    sendByte(8'hAA, 0);
    sendByte(8'hBB, 0);
    reset = 1'b1;
    tick();
    check("midrst_status", {29'd0, busy, done, error}, 32'd0);
    check("midrst_cpu_rdy", {30'd0, cpu_reset, rx_ready}, 32'd2);
    reset = 1'b0;
    tick();
    startLoad();
    sendCount(16'd1);
    sendWord(32'hDEADBEEF, 32'h0, 0);
    waitDone("done_after_rst");

    // Largest accepted count.
    startLoad();
    sendCount(16'd64);
    for (int i = 0; i < 64; i++)
      sendWord(32'hA5000000 | 32'(i * 3), 32'(i * 4), 0);
    waitDone("done_max");
    check("max_last_adr", Ext_DataAdr, 32'h0000_00FC);

    repeat (3) tick();
    check("sb_drained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFails);
    $finish;
  end

endmodule

`default_nettype wire
